bit_timer: RTL and testbench

- Parametrised serial-frame bit timer for the receive datapath. Sits between the start-bit detector and the RX shift register / frame checker.
- After a start trigger, emits one `shift_strobe` per frame bit, with configurable data width, optional parity and 1 or 2 stop bits.
- Emits `packet_done` on the final bit. Counts a single frame per trigger, then rearms.

---
 rtl/bit_timer_pkg.sv | 19 +
 rtl/bit_timer_if.sv | 27 ++
 rtl/bit_timer_cnt.sv | 27 ++
 rtl/bit_timer.sv | 132 +++++++++++++
 tb/tb_bit_timer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_timer_pkg.sv
// Shared types and helpers for the serial-frame bit timer.
package bit_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE_WAIT
  } timer_state_t;

  // Smallest usable bit period; guarantees strobes are never adjacent.
  localparam int unsigned MIN_PERIOD = 2;

  function automatic int unsigned frame_bits(input int unsigned data_size,
                                             input logic        parity_en,
                                             input logic        two_stop);
    return data_size + (parity_en ? 1 : 0) + (two_stop ? 2 : 1);
  endfunction

endpackage

// File: rtl/bit_timer_if.sv
// Control/status bundle between the start-bit detector, bit timer and RX shifter.
interface bit_timer_if #(
  parameter int unsigned CNT_W  = 14,
  parameter int unsigned SIZE_W = 4
);

  logic              enable_timer;
  logic [CNT_W-1:0]  bit_period;
  logic [SIZE_W-1:0] data_size;
  logic              parity_en;
  logic              two_stop;
  logic              shift_strobe;
  logic              packet_done;
  logic              busy;
  logic [SIZE_W:0]   bit_idx;

  modport master (
    output enable_timer, bit_period, data_size, parity_en, two_stop,
    input  shift_strobe, packet_done, busy, bit_idx
  );

  modport slave (
    input  enable_timer, bit_period, data_size, parity_en, two_stop,
    output shift_strobe, packet_done, busy, bit_idx
  );

endinterface

// File: rtl/bit_timer_cnt.sv
// Cycle counter for the bit timer: clear restarts at 1, hit flags cnt == cmp_val.
module bit_timer_cnt #(
  parameter int unsigned W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] cmp_val,
  output logic         hit
);

  logic [W-1:0] cnt;

  // Count value 1 is the first cycle of a bit, so clear loads 1 rather than 0.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= W'(1);
    else if (en)
      cnt <= cnt + W'(1);
  end

  assign hit = (cnt == cmp_val);

endmodule

// File: rtl/bit_timer.sv
// Serial-frame bit timer: one shift_strobe per frame bit after a start trigger.
// Optional BIT_TIMER_MIDSAMPLE_EN: first reload is 1.5 periods (mid-bit sampling).
module bit_timer
  import bit_timer_pkg::*;
#(
  parameter int unsigned CNT_W  = 14,
  parameter int unsigned SIZE_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  bit_timer_if.slave   bus
);

  localparam int unsigned CW = CNT_W + 1;
  localparam int unsigned IW = SIZE_W + 1;

  timer_state_t state_q, state_d;

  logic [CW-1:0] p_in, r1_in;
  logic [CW-1:0] p_q, reload_q, reload_d;
  logic [IW-1:0] n_in, n_q;
  logic [IW-1:0] idx_q, idx_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic          load, cnt_clr, cnt_en, cnt_hit;

  always_comb begin
    p_in = {1'b0, bus.bit_period};
    if (p_in < CW'(MIN_PERIOD))
      p_in = CW'(MIN_PERIOD);
  end

`ifdef BIT_TIMER_MIDSAMPLE_EN
  assign r1_in = p_in + (p_in >> 1);
`else
  assign r1_in = p_in;
`endif

  assign n_in = IW'(frame_bits(32'(bus.data_size), bus.parity_en, bus.two_stop));

  bit_timer_cnt #(.W(CW)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cmp_val (reload_q),
    .hit     (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Abort is tested before the compare so a dropped enable suppresses a due strobe.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    reload_d = reload_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (bus.enable_timer) begin
          state_d  = RUN;
          load     = 1'b1;
          cnt_clr  = 1'b1;
          reload_d = r1_in;
        end
      end
      RUN: begin
        if (!bus.enable_timer) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (cnt_hit) begin
          strobe_d = 1'b1;
          cnt_clr  = 1'b1;
          reload_d = p_q;
          idx_d    = idx_q + IW'(1);
          if (idx_d == n_q) begin
            done_d  = 1'b1;
            state_d = DONE_WAIT;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE_WAIT: begin
        if (!bus.enable_timer) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= '0;
      n_q      <= '0;
      reload_q <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (load) begin
        p_q <= p_in;
        n_q <= n_in;
      end
      reload_q <= reload_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign bus.shift_strobe = strobe_q;
  assign bus.packet_done  = done_q;
  assign bus.busy         = (state_q == RUN);
  assign bus.bit_idx      = idx_q;

endmodule

// File: tb/tb_bit_timer.sv
// Self-checking bench for bit_timer: schedule-based model plus directed literal checks.
module tb_bit_timer;

  localparam int CNT_W  = 14;
  localparam int SIZE_W = 4;

`ifdef BIT_TIMER_MIDSAMPLE_EN
  localparam bit MID = 1'b1;
`else
  localparam bit MID = 1'b0;
`endif

  // Hand-computed first-strobe offsets for the directed frames.
  localparam int R1_P10 = MID ? 15 : 10;
  localparam int R1_P4  = MID ? 6  : 4;
  localparam int R1_P2  = MID ? 3  : 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_timer_if #(.CNT_W(CNT_W), .SIZE_W(SIZE_W)) bus ();

  bit_timer #(.CNT_W(CNT_W), .SIZE_W(SIZE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int strobe_log[$];
  int done_log[$];

  // Model: a frame is a list of strobe instants E0 + R1 + (k-1)*P, k = 1..N.
  int m_mode = 0;   // 0 idle, 1 framing, 2 done-hold
  int m_e0, m_p, m_n, m_r1, m_k, m_el;
  bit e_strobe = 1'b0, e_done = 1'b0, e_busy = 1'b0;
  int e_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int log_at(input int i);
    if (i < strobe_log.size()) return strobe_log[i];
    return -100000;
  endfunction

  function automatic int done_at(input int i);
    if (i < done_log.size()) return done_log[i];
    return -100000;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    e_strobe = 1'b0;
    e_done   = 1'b0;
    if (rst) begin
      m_mode = 0;
      e_idx  = 0;
    end else begin
      case (m_mode)
        0: begin
          e_idx = 0;
          if (bus.enable_timer) begin
            m_mode = 1;
            m_e0   = cyc;
            m_p    = (int'(bus.bit_period) < 2) ? 2 : int'(bus.bit_period);
            m_n    = int'(bus.data_size) + int'(bus.parity_en) + (bus.two_stop ? 2 : 1);
            m_r1   = MID ? m_p + m_p / 2 : m_p;
            m_k    = 0;
          end
        end
        1: begin
          if (!bus.enable_timer) begin
            m_mode = 0;
            e_idx  = 0;
          end else begin
            m_el = cyc - m_e0;
            if (m_el >= m_r1 && (m_el - m_r1) % m_p == 0) begin
              m_k      = m_k + 1;
              e_strobe = 1'b1;
              e_idx    = m_k;
              if (m_k == m_n) begin
                e_done = 1'b1;
                m_mode = 2;
              end
            end
          end
        end
        default: begin
          if (!bus.enable_timer) begin
            m_mode = 0;
            e_idx  = 0;
          end
        end
      endcase
    end
    e_busy = (m_mode == 1);
  end

  always @(posedge clk) begin
    #1;
    chk("shift_strobe", int'(bus.shift_strobe), int'(e_strobe));
    chk("packet_done",  int'(bus.packet_done),  int'(e_done));
    chk("busy",         int'(bus.busy),         int'(e_busy));
    chk("bit_idx",      int'(bus.bit_idx),      e_idx);
    if (bus.shift_strobe) strobe_log.push_back(cyc);
    if (bus.packet_done)  done_log.push_back(cyc);
  end

  task automatic setcfg(input int bp, input int ds, input bit par, input bit ts);
    bus.bit_period = CNT_W'(bp);
    bus.data_size  = SIZE_W'(ds);
    bus.parity_en  = par;
    bus.two_stop   = ts;
  endtask

  task automatic start(output int e0);
    @(negedge clk);
    strobe_log.delete();
    done_log.delete();
    bus.enable_timer = 1'b1;
    e0 = cyc + 1;
  endtask

  task automatic stop_frame();
    @(negedge clk);
    bus.enable_timer = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int e0;
  int bp_list[2] = '{0, 1};

  initial begin
    bus.enable_timer = 1'b0;
    setcfg(10, 8, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_idx",  int'(bus.bit_idx), 0);

    // 8N1 frame, P=10, then hold enable high and retrigger.
    setcfg(10, 8, 1'b0, 1'b0);
    start(e0);
    repeat (R1_P10 + 83) @(negedge clk);
    chk("A_count",    strobe_log.size(), 9);
    chk("A_first",    log_at(0) - e0, R1_P10);
    chk("A_last",     log_at(8) - e0, R1_P10 + 80);
    chk("A_done_cnt", done_log.size(), 1);
    chk("A_done_at",  done_at(0) - e0, R1_P10 + 80);
    chk("A_idx_end",  int'(bus.bit_idx), 9);
    repeat (50) @(negedge clk);
    chk("A_hold_cnt",  strobe_log.size(), 9);
    chk("A_hold_busy", int'(bus.busy), 0);
    stop_frame();
    chk("A_idle_idx", int'(bus.bit_idx), 0);
    start(e0);
    repeat (R1_P10 + 2) @(negedge clk);
    chk("A_re_first", log_at(0) - e0, R1_P10);
    repeat (90) @(negedge clk);
    chk("A_re_count", strobe_log.size(), 9);
    stop_frame();

    // 7 data + parity + 2 stop, P=4; period input changed mid-frame.
    setcfg(4, 7, 1'b1, 1'b1);
    start(e0);
    repeat (3) @(negedge clk);
    bus.bit_period = CNT_W'(20);
    repeat (R1_P4 + 40) @(negedge clk);
    chk("B_count",   strobe_log.size(), 10);
    chk("B_first",   log_at(0) - e0, R1_P4);
    chk("B_gap1",    log_at(1) - log_at(0), 4);
    chk("B_gap9",    log_at(9) - log_at(8), 4);
    chk("B_done_at", done_at(0), log_at(9));
    chk("B_idx_end", int'(bus.bit_idx), 10);
    stop_frame();

    // Degenerate periods clamp to 2.
    foreach (bp_list[i]) begin
      setcfg(bp_list[i], 2, 1'b0, 1'b0);
      start(e0);
      repeat (R1_P2 + 8) @(negedge clk);
      chk("C_count", strobe_log.size(), 3);
      chk("C_first", log_at(0) - e0, R1_P2);
      chk("C_gap1",  log_at(1) - log_at(0), 2);
      chk("C_gap2",  log_at(2) - log_at(1), 2);
      stop_frame();
    end

    // Abort on the edge the 3rd strobe is due.
    setcfg(10, 8, 1'b0, 1'b0);
    start(e0);
    repeat (R1_P10 + 20) @(negedge clk);
    bus.enable_timer = 1'b0;
    @(negedge clk);
    chk("D_count", strobe_log.size(), 2);
    chk("D_done",  done_log.size(), 0);
    chk("D_busy",  int'(bus.busy), 0);
    chk("D_idx",   int'(bus.bit_idx), 0);
    repeat (5) @(negedge clk);

    // Reset after the 4th strobe with enable still high.
    setcfg(10, 8, 1'b0, 1'b0);
    start(e0);
    for (int n = 0; n < 200 && strobe_log.size() < 4; n++) @(negedge clk);
    chk("E_reach4", strobe_log.size(), 4);
    rst = 1'b1;
    @(negedge clk);
    chk("E_rst_strobe", int'(bus.shift_strobe), 0);
    chk("E_rst_done",   int'(bus.packet_done), 0);
    chk("E_rst_busy",   int'(bus.busy), 0);
    chk("E_rst_idx",    int'(bus.bit_idx), 0);
    rst = 1'b0;
    strobe_log.delete();
    done_log.delete();
    e0 = cyc + 1;
    repeat (R1_P10 + 2) @(negedge clk);
    chk("E_re_first", log_at(0) - e0, R1_P10);
    stop_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
